// File: rtl/xor_shift_pkg.sv
// Shared types, constants and the 4-bit rotate helper for the xor_shift
// nibble-hash stage and its sequencer.
package xor_shift_pkg;

    typedef logic [31:0] hword_t;
    typedef logic [3:0]  nib_t;
    typedef logic [2:0]  step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xs_state_t;

    localparam int NIBBLES = 8;

    // Rotate a nibble left by n (mod 4); doubling the nibble lets the
    // wrapped-around bits fall out of a plain shift.
    function automatic nib_t rotl4(input nib_t v, input int n);
        logic [7:0] dbl;
        logic [1:0] r;
        r   = n[1:0];
        dbl = {v, v} << r;
        return dbl[7:4];
    endfunction

endpackage

// File: rtl/xor_shift.sv
// Combinational xor_shift stage: rewrites nibble i of h with
// rotl4(nib[(i+1) mod 8] ^ s, i/2), leaving every other nibble untouched.
module xor_shift
    import xor_shift_pkg::*;
(
    input  hword_t h,
    input  nib_t   s,
    input  step_t  i,
    output hword_t h_modified
);

    step_t src_idx_s;
    nib_t  src_nib_s;
    nib_t  new_nib_s;

    // Select the right-hand neighbour (wrapping 7 -> 0), mix and splice it in.
    always_comb begin
        src_idx_s  = i + 3'd1;
        src_nib_s  = h[{src_idx_s, 2'b00} +: 4];
        new_nib_s  = rotl4(src_nib_s ^ s, int'(i[2:1]));
        h_modified = h;
        for (int k = 0; k < NIBBLES; k++) begin
            if (step_t'(k) == i) begin
                h_modified[4*k +: 4] = new_nib_s;
            end else begin
                h_modified[4*k +: 4] = h[4*k +: 4];
            end
        end
    end

endmodule

// File: rtl/xor_shift_seq.sv
// Sequencer that walks one xor_shift stage over all 8 nibbles of an H word,
// ROUNDS passes per job, with valid/ready on both sides.
// Optional job abort input is enabled by defining XOR_SHIFT_SEQ_ABORT_EN.
module xor_shift_seq
    import xor_shift_pkg::*;
#(
    parameter int ROUNDS = 1
)
(
    input  logic   clk,
    input  logic   rst_n,
`ifdef XOR_SHIFT_SEQ_ABORT_EN
    input  logic   abort,
`endif
    input  logic   in_valid,
    output logic   in_ready,
    input  hword_t h_in,
    input  nib_t   s_in,
    output logic   out_valid,
    input  logic   out_ready,
    output hword_t h_out,
    output logic   busy
);

    if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
        $error("xor_shift_seq: ROUNDS must be in 1..15");
    end

    localparam logic [3:0] LAST_PASS = 4'(ROUNDS - 1);

    xs_state_t  state_q, state_d;
    hword_t     h_q, h_d;
    nib_t       s_q, s_d;
    step_t      step_q, step_d;
    logic [3:0] pass_q, pass_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    hword_t     h_mod_s;
    logic       abort_s;

`ifdef XOR_SHIFT_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    xor_shift u_xor_shift (
        .h          (h_q),
        .s          (s_q),
        .i          (step_q),
        .h_modified (h_mod_s)
    );

    // Next-state logic; output flags are decoded from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        step_d  = step_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                // abort in IDLE only suppresses a simultaneous accept
                if (in_valid && !abort_s) begin
                    h_d     = h_in;
                    s_d     = s_in;
                    step_d  = 3'd0;
                    pass_d  = 4'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    step_d  = 3'd0;
                    pass_d  = 4'd0;
                    state_d = IDLE;
                end else begin
                    h_d    = h_mod_s;
                    step_d = step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        pass_d = pass_q + 4'd1;
                        if (pass_q == LAST_PASS) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                if (abort_s) begin
                    step_d  = 3'd0;
                    pass_d  = 4'd0;
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_q         <= 32'h0000_0000;
            s_q         <= 4'h0;
            step_q      <= 3'd0;
            pass_q      <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            s_q         <= s_d;
            step_q      <= step_d;
            pass_q      <= pass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign h_out     = h_q;

endmodule

// File: tb/tb_xor_shift_seq.sv
// Self-checking bench for xor_shift_seq (ROUNDS=1 and ROUNDS=2 instances)
// against a nibble-array reference model of the hash step.
module tb_xor_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid, out_ready, in_ready, out_valid, busy;
    logic [31:0] h_in, h_out;
    logic [3:0]  s_in;
    logic        in_valid2, out_ready2, in_ready2, out_valid2, busy2;
    logic [31:0] h_in2, h_out2;
    logic [3:0]  s_in2;
`ifdef XOR_SHIFT_SEQ_ABORT_EN
    logic        abort, abort2;
`endif

    int vectors     = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xor_shift_seq #(.ROUNDS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef XOR_SHIFT_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_in      (h_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h_out     (h_out),
        .busy      (busy)
    );

    xor_shift_seq #(.ROUNDS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef XOR_SHIFT_SEQ_ABORT_EN
        .abort     (abort2),
`endif
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .h_in      (h_in2),
        .s_in      (s_in2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .h_out     (h_out2),
        .busy      (busy2)
    );

    // Reference: split into 8 nibbles, rewrite nibble i from its neighbour.
    function automatic logic [31:0] m_step(input logic [31:0] h, input logic [3:0] s, input int i);
        int nib [8];
        int x, r;
        logic [31:0] res;
        for (int k = 0; k < 8; k++) nib[k] = int'((h >> (4 * k)) & 32'hF);
        x = nib[(i + 1) % 8] ^ int'(s);
        r = i / 2;
        nib[i] = ((x << r) | (x >> (4 - r))) & 15;
        res = 32'h0;
        for (int k = 0; k < 8; k++) res = res | (32'(nib[k]) << (4 * k));
        return res;
    endfunction

    function automatic logic [31:0] m_job(input logic [31:0] h, input logic [3:0] s, input int rounds);
        logic [31:0] v;
        v = h;
        for (int p = 0; p < rounds; p++)
            for (int i = 0; i < 8; i++) v = m_step(v, s, i);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One ROUNDS=1 job; hold = cycles out_ready stays low in DONE (0 = always high).
    task automatic run_job(input logic [31:0] h, input logic [3:0] s, input int hold,
                           output logic [31:0] result);
        logic [31:0] exp;
        exp       = h;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        h_in      = h;
        s_in      = s;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        h_in     = $urandom;
        s_in     = 4'($urandom);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_in_ready", 32'(in_ready), 32'd0);
        chk("accept_load", h_out, h);
        for (int i = 0; i < 8; i++) begin
            tick;
            exp = m_step(exp, s, i);
            chk("step_h", h_out, exp);
            chk("out_valid_latency", 32'(out_valid), 32'(i == 7));
        end
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            tick;
            chk("hold_h", h_out, exp);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
        result    = exp;
    endtask

    initial begin
        logic [31:0] res, h, exp;
        logic [3:0]  s;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; h_in = 32'h0; s_in = 4'h0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; h_in2 = 32'h0; s_in2 = 4'h0;
`ifdef XOR_SHIFT_SEQ_ABORT_EN
        abort = 1'b0; abort2 = 1'b0;
`endif
        #3;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_h_out", h_out, 32'h0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        run_job(32'h0000_0000, 4'hF, 0, res);
        chk("zero_F_result", res, 32'h0FFF_FFFF);
        run_job(32'h1234_5678, 4'h0, 0, res);
        chk("vec_result", res, 32'hB88C_8A67);
        run_job(32'h1234_5678, 4'h0, 5, res);
        chk("vec_hold_result", h_out, 32'hB88C_8A67);

        // ROUNDS=2: output after 16 steps, equal to two passes of the model
        in_valid2 = 1'b1; h_in2 = 32'h0; s_in2 = 4'hF; out_ready2 = 1'b1;
        tick;
        in_valid2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick;
            chk("r2_valid_latency", 32'(out_valid2), 32'(i == 15));
        end
        chk("r2_result", h_out2, m_job(32'h0FFF_FFFF, 4'hF, 1));
        chk("r2_result_job", h_out2, m_job(32'h0, 4'hF, 2));
        tick;
        chk("r2_release_valid", 32'(out_valid2), 32'd0);
        chk("r2_release_in_ready", 32'(in_ready2), 32'd1);

        // reset in the middle of a job
        in_valid = 1'b1; h_in = 32'hDEAD_BEEF; s_in = 4'h5;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        chk("mid_job_h", h_out, m_step(m_step(m_step(m_step(32'hDEAD_BEEF, 4'h5, 0), 4'h5, 1), 4'h5, 2), 4'h5, 3));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_h", h_out, 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("after_reset_in_ready", 32'(in_ready), 32'd1);
        run_job(32'h1234_5678, 4'h0, 0, res);
        chk("after_reset_result", res, 32'hB88C_8A67);

        // randomized jobs checked against the model
        for (int n = 0; n < 12; n++) begin
            h = $urandom;
            s = 4'($urandom);
            run_job(h, s, int'($urandom_range(0, 3)), res);
            chk("rand_result", h_out, m_job(h, s, 1));
        end

        // randomized ROUNDS=2 job
        h = $urandom; s = 4'($urandom);
        exp = m_job(h, s, 2);
        in_valid2 = 1'b1; h_in2 = h; s_in2 = s; out_ready2 = 1'b1;
        tick;
        in_valid2 = 1'b0; h_in2 = $urandom; s_in2 = 4'($urandom);
        repeat (16) tick;
        chk("r2_rand_valid", 32'(out_valid2), 32'd1);
        chk("r2_rand_result", h_out2, exp);
        tick;

`ifdef XOR_SHIFT_SEQ_ABORT_EN
        // abort at step 3
        in_valid = 1'b1; h_in = 32'h1234_5678; s_in = 4'h0; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_run_busy", 32'(busy), 32'd0);
        chk("abort_run_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("abort_run_no_valid", 32'(out_valid), 32'd0);
        end
        // abort beside in_valid in IDLE blocks the accept
        abort = 1'b1; in_valid = 1'b1;
        tick;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_in_ready", 32'(in_ready), 32'd1);
        // abort in DONE drops out_valid
        in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        repeat (8) tick;
        chk("abort_done_pre_valid", 32'(out_valid), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_done_valid", 32'(out_valid), 32'd0);
        chk("abort_done_in_ready", 32'(in_ready), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
